// File: rtl/cam_fifo_reader.sv
// Reads one RGB565 frame out of a camera line FIFO (high byte first) and emits
// RGB333 pixel writes with (x, y) coordinates, one pixel every four clocks.
module cam_fifo_reader #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter int unsigned RRST_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] fifo_data,
    output logic       fifo_rclk,
    output logic       fifo_rrst,
    output logic       fifo_oe,
    output logic       pix_we,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic [8:0] pix_data,
    output logic       busy,
    output logic       done
);

    localparam int unsigned RrstLen = 2 * RRST_CYCLES;
    localparam int unsigned RrstW   = (RrstLen > 1) ? $clog2(RrstLen) : 1;
    localparam logic [RrstW-1:0] RrstLast = RrstW'(RrstLen - 1);
    localparam logic [8:0] XLast = 9'(WIDTH - 1);
    localparam logic [7:0] YLast = 8'(HEIGHT - 1);

    typedef enum logic [2:0] {StIdle, StRrst, StRdHi, StRdLo, StDone} state_e;

    state_e           state_q;
    logic [RrstW-1:0] rrst_cnt_q;
    logic [7:0]       hi_q;
    logic             last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rrst_cnt_q <= '0;
            hi_q       <= '0;
            last_q     <= 1'b0;
            fifo_rclk  <= 1'b0;
            fifo_rrst  <= 1'b1;
            fifo_oe    <= 1'b1;
            pix_we     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pix_we <= 1'b0;
            done   <= 1'b0;

            // Coordinates advance on the edge that ends the write strobe.
            if (pix_we) begin
                if (pix_x == XLast) begin
                    pix_x <= '0;
                    pix_y <= (pix_y == YLast) ? 8'd0 : pix_y + 8'd1;
                end else begin
                    pix_x <= pix_x + 9'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    fifo_rclk <= 1'b0;
                    if (start) begin
                        state_q    <= StRrst;
                        busy       <= 1'b1;
                        fifo_oe    <= 1'b0;
                        fifo_rrst  <= 1'b0;
                        rrst_cnt_q <= '0;
                    end
                end
                StRrst: begin
                    fifo_rclk  <= ~fifo_rclk;
                    rrst_cnt_q <= rrst_cnt_q + 1'b1;
                    if (rrst_cnt_q == RrstLast) begin
                        fifo_rrst <= 1'b1;
                        state_q   <= StRdHi;
                    end
                end
                StRdHi: begin
                    fifo_rclk <= ~fifo_rclk;
                    if (fifo_rclk) begin
                        hi_q    <= fifo_data;
                        state_q <= StRdLo;
                    end
                end
                StRdLo: begin
                    // After the final pixel, hold one extra low-phase cycle so
                    // done follows the last strobe rather than coinciding with it.
                    if (last_q) begin
                        last_q    <= 1'b0;
                        fifo_rclk <= 1'b0;
                        fifo_oe   <= 1'b1;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        fifo_rclk <= ~fifo_rclk;
                        if (fifo_rclk) begin
                            pix_data <= {hi_q[7:5], hi_q[2:0], fifo_data[4:2]};
                            pix_we   <= 1'b1;
                            if (pix_x == XLast && pix_y == YLast) begin
                                last_q <= 1'b1;
                            end else begin
                                state_q <= StRdHi;
                            end
                        end
                    end
                end
                StDone: begin
                    fifo_rclk <= 1'b0;
                    busy      <= 1'b0;
                    pix_x     <= '0;
                    pix_y     <= '0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
